// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with branch/redirect priority and a circular return-address stack.
module pc_gen #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    IMM_WIDTH    = 13,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [DATA_WIDTH-1:0]        redirect_target,
    input  logic                         PCsrc,
    input  logic [IMM_WIDTH-1:0]         ImmOp,
    input  logic                         is_call,
    input  logic                         is_ret,
    output logic [DATA_WIDTH-1:0]        PC,
    output logic [DATA_WIDTH-1:0]        PC_plus4,
    output logic                         pc_misaligned,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [DATA_WIDTH-1:0] pc_q, pc_d, imm_ext;
    logic                  mis_q;
    logic [PW-1:0]         ptr_q, ptr_d, top_idx, wr_idx;
    logic [PW:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic                  upd, has, push, pop, replace, wr_en;

    assign PC            = pc_q;
    assign PC_plus4      = pc_q + DATA_WIDTH'(4);
    assign pc_misaligned = mis_q;
    assign ras_count     = cnt_q;
    assign imm_ext       = {{(DATA_WIDTH-IMM_WIDTH){ImmOp[IMM_WIDTH-1]}}, ImmOp};
    // ptr_q is the next free slot; the top of stack sits just below it
    assign top_idx       = ptr_q - PW'(1);

    always_comb begin
        upd     = !stall && !redirect_valid;
        has     = cnt_q != '0;
        push    = upd && is_call && (!is_ret || !has);
        replace = upd && is_call && is_ret && has;
        pop     = upd && is_ret && !is_call && has;
        wr_en   = push || replace;
        wr_idx  = replace ? top_idx : ptr_q;
        ptr_d   = push ? ptr_q + PW'(1) : pop ? top_idx : ptr_q;
        cnt_d   = push ? (cnt_q == (PW+1)'(RAS_DEPTH) ? cnt_q : cnt_q + (PW+1)'(1))
                : pop  ? cnt_q - (PW+1)'(1) : cnt_q;
        pc_d    = redirect_valid ? redirect_target
                : stall          ? pc_q
                : PCsrc          ? pc_q + imm_ext
                : (is_ret && has) ? ras_q[top_idx]
                : PC_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= RESET_VECTOR[1:0] != 2'b00;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= pc_d[1:0] != 2'b00;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            ras_q[wr_idx] <= PC_plus4;
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenario tasks for pc_gen with hand-computed expectations.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, PCsrc, is_call, is_ret;
    logic [31:0] redirect_target;
    logic [12:0] ImmOp;
    logic [31:0] PC, PC_plus4;
    logic        pc_misaligned;
    logic [2:0]  ras_count;
    int          total = 0;
    int          bad = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .PCsrc(PCsrc), .ImmOp(ImmOp),
        .is_call(is_call), .is_ret(is_ret), .PC(PC), .PC_plus4(PC_plus4),
        .pc_misaligned(pc_misaligned), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stall = 0; redirect_valid = 0; redirect_target = '0;
        PCsrc = 0; ImmOp = '0; is_call = 0; is_ret = 0;
    endtask

    task automatic jump(input logic [31:0] t);
        idle();
        redirect_valid = 1; redirect_target = t;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ras_count); end
        total++; if (pc_misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", pc_misaligned); end
        total++; if (PC_plus4 !== 32'h4) begin bad++; $display("FAIL reset_plus4 got=%h exp=4", PC_plus4); end
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (PC !== 32'(4 * i)) begin bad++; $display("FAIL idle_pc%0d got=%h exp=%h", i, PC, 32'(4 * i)); end
        end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL idle_cnt got=%0d exp=0", ras_count); end
    endtask

    task automatic test_branch();
        jump(32'h100);
        PCsrc = 1; ImmOp = 13'h1FF8;
        step();
        idle();
        total++; if (PC !== 32'hF8) begin bad++; $display("FAIL branch_neg got=%h exp=000000f8", PC); end
        jump(32'hFFFF_FFFC);
        total++; if (pc_misaligned !== 1'b0) begin bad++; $display("FAIL wrap_mis got=%b exp=0", pc_misaligned); end
        step();
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", PC); end
    endtask

    task automatic test_call_ret();
        jump(32'h200);
        is_call = 1; PCsrc = 1; ImmOp = 13'h40;
        step();
        idle();
        total++; if (PC !== 32'h240) begin bad++; $display("FAIL call_pc got=%h exp=240", PC); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL call_cnt got=%0d exp=1", ras_count); end
        jump(32'h250);
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL redir_keep_cnt got=%0d exp=1", ras_count); end
        is_ret = 1;
        step();
        idle();
        total++; if (PC !== 32'h204) begin bad++; $display("FAIL ret_pc got=%h exp=204", PC); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL ret_cnt got=%0d exp=0", ras_count); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret = '{32'h1404, 32'h1304, 32'h1204, 32'h1104};
        jump(32'h1000);
        for (int i = 0; i < 5; i++) begin
            is_call = 1; PCsrc = 1; ImmOp = 13'h100;
            step();
        end
        idle();
        total++; if (PC !== 32'h1500) begin bad++; $display("FAIL ovf_pc got=%h exp=1500", PC); end
        total++; if (ras_count !== 3'd4) begin bad++; $display("FAIL ovf_cnt got=%0d exp=4", ras_count); end
        for (int i = 0; i < 4; i++) begin
            is_ret = 1;
            step();
            total++; if (PC !== exp_ret[i]) begin bad++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, PC, exp_ret[i]); end
            total++; if (ras_count !== 3'(3 - i)) begin bad++; $display("FAIL ovf_retcnt%0d got=%0d exp=%0d", i, ras_count, 3 - i); end
        end
        step();
        idle();
        total++; if (PC !== 32'h1108) begin bad++; $display("FAIL empty_ret got=%h exp=1108", PC); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL empty_cnt got=%0d exp=0", ras_count); end
    endtask

    task automatic test_stall();
        jump(32'h3000);
        is_call = 1;
        step();
        total++; if (PC !== 32'h3004 || ras_count !== 3'd1) begin bad++; $display("FAIL pre_stall got=%h/%0d exp=3004/1", PC, ras_count); end
        stall = 1;
        step();
        step();
        total++; if (PC !== 32'h3004) begin bad++; $display("FAIL stall_pc got=%h exp=3004", PC); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL stall_cnt got=%0d exp=1", ras_count); end
        redirect_valid = 1; redirect_target = 32'h1002; is_ret = 1;
        step();
        idle();
        total++; if (PC !== 32'h1002) begin bad++; $display("FAIL stall_redir_pc got=%h exp=1002", PC); end
        total++; if (pc_misaligned !== 1'b1) begin bad++; $display("FAIL stall_redir_mis got=%b exp=1", pc_misaligned); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL stall_redir_cnt got=%0d exp=1", ras_count); end
        is_ret = 1;
        step();
        idle();
        total++; if (PC !== 32'h3004) begin bad++; $display("FAIL stall_ras_data got=%h exp=3004", PC); end
        total++; if (pc_misaligned !== 1'b0) begin bad++; $display("FAIL realign_mis got=%b exp=0", pc_misaligned); end
    endtask

    task automatic test_call_and_ret();
        jump(32'h4000);
        is_call = 1; is_ret = 1;
        step();
        total++; if (PC !== 32'h4004 || ras_count !== 3'd1) begin bad++; $display("FAIL both_empty got=%h/%0d exp=4004/1", PC, ras_count); end
        step();
        idle();
        total++; if (PC !== 32'h4004 || ras_count !== 3'd1) begin bad++; $display("FAIL both_full got=%h/%0d exp=4004/1", PC, ras_count); end
        is_ret = 1;
        step();
        idle();
        total++; if (PC !== 32'h4008 || ras_count !== 3'd0) begin bad++; $display("FAIL both_pop got=%h/%0d exp=4008/0", PC, ras_count); end
    endtask

    task automatic test_reset_priority();
        jump(32'h5000);
        is_call = 1;
        step();
        step();
        total++; if (ras_count !== 3'd2) begin bad++; $display("FAIL prerst_cnt got=%0d exp=2", ras_count); end
        rst = 1; redirect_valid = 1; redirect_target = 32'h7777; stall = 1;
        step();
        idle();
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL rstpri_pc got=%h exp=0", PC); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL rstpri_cnt got=%0d exp=0", ras_count); end
        is_ret = 1;
        step();
        idle();
        total++; if (PC !== 32'h4) begin bad++; $display("FAIL rstpri_ret got=%h exp=4", PC); end
    endtask

    initial begin
        idle();
        test_reset();
        test_branch();
        test_call_ret();
        test_ras_overflow();
        test_stall();
        test_call_and_ret();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
